key_scanner: RTL

- Downstream consumer of the camera frame buffer (128x256 words of RGB333, read port on mem_clk, 1-cycle registered read).
- Scans a rectangular keyboard window once per start request and counts "dark" (finger/shadow) pixels in each of NUM_KEYS equal-width column strips.
- Applies press/release hysteresis and publishes a stable key bitmap plus new-press pulses to the note/sound logic.

---
 rtl/cam_pkg.sv | 31 +++
 rtl/key_scanner_if.sv | 17 +
 rtl/pixel_classify.sv | 16 +
 rtl/key_scanner.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Frame-buffer geometry, pixel field layout and scanner state encoding shared by
// the camera-side consumers.
package cam_pkg;
  localparam int FB_Y_BITS = 7;
  localparam int FB_X_BITS = 8;
  localparam int PIX_W     = 9;

  localparam int R_MSB = 8;
  localparam int R_LSB = 6;
  localparam int G_MSB = 5;
  localparam int G_LSB = 3;
  localparam int B_MSB = 2;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } scan_state_t;

  // Word address into the 128x256 buffer: y in [24:18], x in [9:2].
  function automatic logic [31:0] fb_addr(input logic [FB_Y_BITS-1:0] y,
                                          input logic [FB_X_BITS-1:0] x);
    logic [31:0] a;
    a        = '0;
    a[24:18] = y;
    a[9:2]   = x;
    return a;
  endfunction
endpackage

// File: rtl/key_scanner_if.sv
// Start/address/pixel/result bundle between the key scanner and its neighbours.
interface key_scanner_if
  import cam_pkg::*;
#(
  parameter int NUM_KEYS = 8
);
  logic                start;
  logic [31:0]         addr;
  logic [PIX_W-1:0]    q;
  logic                busy;
  logic                done;
  logic [NUM_KEYS-1:0] keys;
  logic [NUM_KEYS-1:0] key_down;

  modport master (input start, q, output addr, busy, done, keys, key_down);
  modport slave  (output start, q, input addr, busy, done, keys, key_down);
endinterface

// File: rtl/pixel_classify.sv
// Combinational dark-pixel test on an RGB333 word; reused by the marker tracker.
module pixel_classify
  import cam_pkg::*;
#(
  parameter int DARK_TH = 6
) (
  input  logic [PIX_W-1:0] q,
  output logic             dark
);
  logic [4:0] sum;

  always_comb begin
    sum  = {2'b00, q[R_MSB:R_LSB]} + {2'b00, q[G_MSB:G_LSB]} + {2'b00, q[B_MSB:B_LSB]};
    dark = (int'(sum) < DARK_TH);
  end
endmodule

// File: rtl/key_scanner.sv
// Scans the keyboard window of the frame buffer, counts dark pixels per key strip
// and publishes a hysteresis-filtered key bitmap with new-press pulses.
module key_scanner
  import cam_pkg::*;
#(
  parameter int NUM_KEYS = 8,
  parameter int KEY_W    = 20,
  parameter int X0       = 0,
  parameter int Y0       = 80,
  parameter int Y1       = 119,
  parameter int DARK_TH  = 6,
  parameter int ON_TH    = 200,
  parameter int OFF_TH   = 120
) (
  input  logic              mem_clk,
  input  logic              rst,
  key_scanner_if.master     bus
);
  localparam int X_LAST = X0 + NUM_KEYS * KEY_W - 1;
  localparam int SUB_W  = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int KIDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

  scan_state_t          state;
  logic                 drain;
  logic [FB_X_BITS-1:0] x;
  logic [FB_Y_BITS-1:0] y;
  logic [SUB_W-1:0]     sub;
  logic [KIDX_W-1:0]    kidx;
  logic                 vld_p0, vld_p1;
  logic [KIDX_W-1:0]    kidx_p0, kidx_p1;
  logic                 dark;
  logic                 clr_cnt;
  logic [15:0]          cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0]  keys_nxt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  pixel_classify #(.DARK_TH(DARK_TH)) u_classify (
    .q    (bus.q),
    .dark (dark)
  );

  assign clr_cnt = (state == S_IDLE) && bus.start;

  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      drain        <= 1'b0;
      x            <= '0;
      y            <= '0;
      sub          <= '0;
      kidx         <= '0;
      vld_p0       <= 1'b0;
      bus.addr     <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.keys     <= '0;
      bus.key_down <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.key_down <= '0;
      vld_p0       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state    <= S_SCAN;
            bus.busy <= 1'b1;
            x        <= FB_X_BITS'(X0);
            y        <= FB_Y_BITS'(Y0);
            sub      <= '0;
            kidx     <= '0;
          end
        end
        S_SCAN: begin
          bus.addr <= fb_addr(y, x);
          vld_p0   <= 1'b1;
          if (x == FB_X_BITS'(X_LAST)) begin
            x    <= FB_X_BITS'(X0);
            sub  <= '0;
            kidx <= '0;
            if (y == FB_Y_BITS'(Y1)) begin
              state <= S_DRAIN;
              drain <= 1'b0;
            end else begin
              y <= y + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
            if (sub == SUB_W'(KEY_W - 1)) begin
              sub  <= '0;
              kidx <= kidx + 1'b1;
            end else begin
              sub <= sub + 1'b1;
            end
          end
        end
        // Two cycles let the last pixel pass the read latency and accumulate.
        S_DRAIN: begin
          if (drain) begin
            state    <= S_DONE;
            bus.busy <= 1'b0;
          end else begin
            drain <= 1'b1;
          end
        end
        S_DONE: begin
          state        <= S_IDLE;
          bus.keys     <= keys_nxt;
          bus.key_down <= keys_nxt & ~bus.keys;
          bus.done     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // p0 -> p1: key tag waits out the frame-buffer read cycle alongside its valid.
  always_ff @(posedge mem_clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= vld_p0;
  end

  always_ff @(posedge mem_clk) begin
    kidx_p0 <= kidx;
    kidx_p1 <= kidx_p0;
  end

  // p1 + q: accumulate into the tagged strip, then apply press/release hysteresis.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [15:0] acc;

    always_ff @(posedge mem_clk or negedge rst) begin
      if (!rst)
        acc <= '0;
      else if (clr_cnt)
        acc <= '0;
      else if (vld_p1 && dark && (kidx_p1 == KIDX_W'(i)))
        acc <= sat_inc(acc);
    end

    assign cnt[i]      = acc;
    assign keys_nxt[i] = bus.keys[i] ? (acc >= 16'(OFF_TH)) : (acc >= 16'(ON_TH));
  end
endmodule
